// File: rtl/keystream_xor_cipher.sv
// Keystream XOR cipher: prefetches generator bytes into a small FIFO and XORs
// each accepted plaintext byte with the oldest keystream byte.
module keystream_xor_cipher #(
  parameter int KS_DEPTH    = 4,
  parameter int REQ_TIMEOUT = 64
) (
  input  logic                          clk,
  input  logic                          nrst,
  input  logic                          restart,
  input  logic [7:0]                    in_byte,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [7:0]                    out_byte,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          request_hash_byte_pulse,
  input  logic [7:0]                    hash_byte_in,
  input  logic                          hash_byte_pulse_in,
  output logic                          reset_hash_out,
  output logic [31:0]                   byte_count_out,
  output logic [$clog2(KS_DEPTH+1)-1:0] ks_level_out,
  output logic                          timeout_err_out
);

  localparam int PW = (KS_DEPTH > 1) ? $clog2(KS_DEPTH) : 1;
  localparam int LW = $clog2(KS_DEPTH + 1);
  localparam int TW = (REQ_TIMEOUT > 1) ? $clog2(REQ_TIMEOUT) : 1;

  typedef enum logic {REQ_IDLE, REQ_WAIT} req_state_t;

  req_state_t    state_reg;
  logic [TW-1:0] timer_reg;
  logic          request_reg;
  logic          timeout_err_reg;

  logic [7:0]    ks_mem [KS_DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [LW-1:0] level_reg;
  logic [LW-1:0] level_next;

  logic [7:0]    out_byte_reg;
  logic          out_valid_reg;
  logic [31:0]   byte_count_reg;

  logic          clear;
  logic          push;
  logic          pop;
  logic [7:0]    ks_head;

  assign clear    = !nrst || restart;
  // Only a pulse answering an outstanding request is stored; strays in IDLE are dropped.
  assign push     = (state_reg == REQ_WAIT) && hash_byte_pulse_in;
  assign in_ready = (level_reg != '0) && (!out_valid_reg || out_ready);
  assign pop      = in_valid && in_ready;
  assign ks_head  = ks_mem[rd_ptr_reg];

  always_comb begin
    level_next = level_reg;
    if (push && !pop) begin
      level_next = level_reg + 1'b1;
    end else if (!push && pop) begin
      level_next = level_reg - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!clear && push) begin
      ks_mem[wr_ptr_reg] <= hash_byte_in;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_reg       <= REQ_IDLE;
      timer_reg       <= '0;
      request_reg     <= 1'b0;
      timeout_err_reg <= 1'b0;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      level_reg       <= '0;
      out_byte_reg    <= 8'h00;
      out_valid_reg   <= 1'b0;
      byte_count_reg  <= 32'd0;
    end else begin
      request_reg <= 1'b0;
      case (state_reg)
        REQ_IDLE: begin
          // Level is exact here since no reply is pending, so the FIFO cannot overflow.
          if (level_reg < LW'(KS_DEPTH)) begin
            request_reg <= 1'b1;
            state_reg   <= REQ_WAIT;
            timer_reg   <= '0;
          end
        end
        REQ_WAIT: begin
          if (hash_byte_pulse_in) begin
            state_reg <= REQ_IDLE;
          end else if (timer_reg == TW'(REQ_TIMEOUT - 1)) begin
            timeout_err_reg <= 1'b1;
            state_reg       <= REQ_IDLE;
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end
      endcase

      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      level_reg <= level_next;

      if (pop) begin
        out_byte_reg   <= in_byte ^ ks_head;
        out_valid_reg  <= 1'b1;
        byte_count_reg <= byte_count_reg + 32'd1;
      end else if (out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_byte                = out_byte_reg;
  assign out_valid               = out_valid_reg;
  assign request_hash_byte_pulse = request_reg;
  assign reset_hash_out          = restart;
  assign byte_count_out          = byte_count_reg;
  assign ks_level_out            = level_reg;
  assign timeout_err_out         = timeout_err_reg;

endmodule

// File: tb/tb_keystream_xor_cipher.sv
// Bench for keystream_xor_cipher: directed table/corner sequences plus a random
// run scored against a queue-based keystream/ciphertext model.
module tb_keystream_xor_cipher;

  localparam int KS_DEPTH    = 4;
  localparam int REQ_TIMEOUT = 64;
  localparam int LW          = $clog2(KS_DEPTH + 1);

  logic          clk = 1'b0;
  logic          nrst;
  logic          restart;
  logic [7:0]    in_byte;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    out_byte;
  logic          out_valid;
  logic          out_ready;
  logic          request_hash_byte_pulse;
  logic [7:0]    hash_byte_in;
  logic          hash_byte_pulse_in;
  logic          reset_hash_out;
  logic [31:0]   byte_count_out;
  logic [LW-1:0] ks_level_out;
  logic          timeout_err_out;

  keystream_xor_cipher #(.KS_DEPTH(KS_DEPTH), .REQ_TIMEOUT(REQ_TIMEOUT)) dut (
    .clk                     (clk),
    .nrst                    (nrst),
    .restart                 (restart),
    .in_byte                 (in_byte),
    .in_valid                (in_valid),
    .in_ready                (in_ready),
    .out_byte                (out_byte),
    .out_valid               (out_valid),
    .out_ready               (out_ready),
    .request_hash_byte_pulse (request_hash_byte_pulse),
    .hash_byte_in            (hash_byte_in),
    .hash_byte_pulse_in      (hash_byte_pulse_in),
    .reset_hash_out          (reset_hash_out),
    .byte_count_out          (byte_count_out),
    .ks_level_out            (ks_level_out),
    .timeout_err_out         (timeout_err_out)
  );

  always #5 clk = ~clk;

  int vec_count  = 0;
  int miss_count = 0;

  // Generator model controls (written by the main process, read by the generator).
  int         gen_delay = 3;
  bit         gen_en    = 1'b0;
  bit         gen_rand  = 1'b0;
  bit         man_pulse = 1'b0;
  logic [7:0] man_byte  = 8'h00;
  logic [7:0] gen_tab [16];

  typedef struct {
    logic [7:0] ks;
    logic [7:0] pt;
    logic [7:0] ct;
  } vec_t;
  vec_t tab [8];

  // Generator: replies gen_delay cycles after seeing a request, or on a manual pulse.
  initial begin
    int gen_cd;
    int gen_idx;
    gen_cd  = 0;
    gen_idx = 0;
    hash_byte_pulse_in = 1'b0;
    hash_byte_in       = 8'h00;
    forever begin
      @(posedge clk);
      #2;
      hash_byte_pulse_in = 1'b0;
      if (!nrst) begin
        gen_cd  = 0;
        gen_idx = 0;
      end else if (man_pulse) begin
        hash_byte_pulse_in = 1'b1;
        hash_byte_in       = man_byte;
      end else begin
        if (gen_cd > 0) begin
          gen_cd--;
          if (gen_cd == 0) begin
            hash_byte_pulse_in = 1'b1;
            hash_byte_in       = gen_rand ? 8'($urandom) : gen_tab[gen_idx % 16];
            gen_idx++;
          end
        end
        if (gen_en && request_hash_byte_pulse) gen_cd = gen_delay;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_count++;
    if (act !== exp) begin
      miss_count++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_event(input string name);
    vec_count++;
    miss_count++;
    $display("FAIL %s: got no event, expected one within the cycle budget", name);
  endtask

  task automatic do_reset();
    nrst = 1'b0; restart = 1'b0; in_valid = 1'b0; in_byte = 8'h00; out_ready = 1'b0;
    step();
    step();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_level", 32'(ks_level_out), 32'd0);
    check("rst_count", byte_count_out, 32'd0);
    check("rst_err", 32'(timeout_err_out), 32'd0);
    check("rst_request", 32'(request_hash_byte_pulse), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    nrst = 1'b1;
  endtask

  task automatic wait_request(input string name);
    for (int i = 0; i < 200; i++) begin
      if (request_hash_byte_pulse) return;
      step();
    end
    fail_event(name);
  endtask

  task automatic wait_in_ready(input string name);
    for (int i = 0; i < 100; i++) begin
      if (in_ready) return;
      step();
    end
    fail_event(name);
  endtask

  task automatic man_reply(input logic [7:0] b);
    wait_request("man_reply_req");
    man_byte  = b;
    man_pulse = 1'b1;
    step();
    man_pulse = 1'b0;
  endtask

  initial begin
    logic [7:0] ks_q [$];
    logic [7:0] exp_q [$];
    int         req_n;
    int         model_count;
    logic       exp_ir;
    logic [7:0] eb;

    tab[0] = '{8'h3C, 8'h00, 8'h3C};
    tab[1] = '{8'h5A, 8'hFF, 8'hA5};
    tab[2] = '{8'hFF, 8'hFF, 8'h00};
    tab[3] = '{8'h00, 8'hA5, 8'hA5};
    tab[4] = '{8'h81, 8'h7E, 8'hFF};
    tab[5] = '{8'h12, 8'h34, 8'h26};
    tab[6] = '{8'hAA, 8'h55, 8'hFF};
    tab[7] = '{8'hF0, 8'h0F, 8'hFF};
    for (int i = 0; i < 16; i++) gen_tab[i] = (i < 8) ? tab[i].ks : 8'(i * 17);

    // Fill: 4 requests then silence, FIFO full.
    gen_en = 1'b1; gen_delay = 3; gen_rand = 1'b0;
    do_reset();
    out_ready = 1'b1;
    req_n = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (request_hash_byte_pulse) req_n++;
    end
    check("fill_requests", 32'(req_n), 32'd4);
    check("fill_level", 32'(ks_level_out), 32'd4);

    // XOR table: one accept per entry, result visible one cycle later.
    for (int i = 0; i < 8; i++) begin
      wait_in_ready("xor_in_ready");
      in_byte  = tab[i].pt;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      $display("vector %0d: ks=%02h pt=%02h -> out=%02h valid=%0b count=%0d", i, tab[i].ks,
               tab[i].pt, out_byte, out_valid, byte_count_out);
      check("xor_valid", 32'(out_valid), 32'd1);
      check("xor_byte", 32'(out_byte), 32'(tab[i].ct));
      check("xor_count", byte_count_out, 32'(i + 1));
    end

    // Backpressure: output held while out_ready is low.
    do_reset();
    wait_in_ready("bp_in_ready");
    in_byte = 8'h11; in_valid = 1'b1;
    step();
    in_byte = 8'h22;
    check("bp_first_valid", 32'(out_valid), 32'd1);
    check("bp_first_byte", 32'(out_byte), 32'h2D);
    for (int k = 0; k < 5; k++) begin
      step();
      check("bp_hold_byte", 32'(out_byte), 32'h2D);
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready_low", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    check("bp_next_byte", 32'(out_byte), 32'h78);
    check("bp_next_valid", 32'(out_valid), 32'd1);
    step();
    check("bp_drained", 32'(out_valid), 32'd0);

    // Simultaneous push and pop at level 2.
    gen_en = 1'b0;
    do_reset();
    out_ready = 1'b1;
    man_reply(8'hA1);
    man_reply(8'hB2);
    check("pp_level_before", 32'(ks_level_out), 32'd2);
    wait_request("pp_req");
    man_byte = 8'hC3; man_pulse = 1'b1;
    in_byte = 8'h0F; in_valid = 1'b1;
    step();
    man_pulse = 1'b0;
    check("pp_level_same", 32'(ks_level_out), 32'd2);
    check("pp_byte0", 32'(out_byte), 32'hAE);
    in_byte = 8'h00;
    step();
    check("pp_byte1", 32'(out_byte), 32'hB2);
    in_byte = 8'hFF;
    step();
    in_valid = 1'b0;
    check("pp_byte2", 32'(out_byte), 32'h3C);
    check("pp_level_end", 32'(ks_level_out), 32'd0);

    // Timeout: no reply, sticky error 64 cycles after the request, re-request next cycle.
    do_reset();
    wait_request("to_req");
    for (int k = 0; k < REQ_TIMEOUT - 1; k++) step();
    check("to_err_early", 32'(timeout_err_out), 32'd0);
    step();
    check("to_err_set", 32'(timeout_err_out), 32'd1);
    check("to_no_req_yet", 32'(request_hash_byte_pulse), 32'd0);
    step();
    check("to_rerequest", 32'(request_hash_byte_pulse), 32'd1);
    check("to_err_sticky", 32'(timeout_err_out), 32'd1);

    // Restart mid-stream with a request pending and a late pulse.
    do_reset();
    man_reply(8'h11);
    man_reply(8'h22);
    out_ready = 1'b0;
    wait_in_ready("rs_in_ready");
    in_byte = 8'h00; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("rs_count_pre", byte_count_out, 32'd1);
    wait_request("rs_req");
    restart = 1'b1;
    man_byte = 8'hEE; man_pulse = 1'b1;
    #1;
    check("rs_hash_reset", 32'(reset_hash_out), 32'd1);
    step();
    restart = 1'b0;
    check("rs_level", 32'(ks_level_out), 32'd0);
    check("rs_count", byte_count_out, 32'd0);
    check("rs_out_valid", 32'(out_valid), 32'd0);
    step();
    man_pulse = 1'b0;
    check("rs_late_pulse_level", 32'(ks_level_out), 32'd0);
    check("rs_rerequest", 32'(request_hash_byte_pulse), 32'd1);
    check("rs_hash_reset_low", 32'(reset_hash_out), 32'd0);
    step();
    check("rs_level_after", 32'(ks_level_out), 32'd0);

    // Random traffic against the queue model.
    gen_en = 1'b1; gen_rand = 1'b1; gen_delay = 2;
    do_reset();
    model_count = 0;
    for (int i = 0; i < 3020; i++) begin
      if (i < 3000) begin
        in_valid  = ($urandom % 4) != 0;
        in_byte   = 8'($urandom);
        out_ready = ($urandom % 4) != 0;
        if (($urandom % 16) == 0) gen_delay = 1 + int'($urandom % 8);
      end else begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end
      @(negedge clk);
      exp_ir = (ks_q.size() != 0) && (!out_valid || out_ready);
      check("rnd_in_ready", 32'(in_ready), 32'(exp_ir));
      if (hash_byte_pulse_in) ks_q.push_back(hash_byte_in);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) fail_event("rnd_unexpected_output");
        else begin
          eb = exp_q.pop_front();
          check("rnd_out_byte", 32'(out_byte), 32'(eb));
        end
      end
      if (in_valid && in_ready) begin
        if (ks_q.size() == 0) fail_event("rnd_keystream_underflow");
        else begin
          exp_q.push_back(in_byte ^ ks_q.pop_front());
          model_count++;
        end
      end
      step();
      check("rnd_level", 32'(ks_level_out), 32'(ks_q.size()));
      check("rnd_count", byte_count_out, 32'(model_count));
    end
    check("rnd_drained", 32'(exp_q.size()), 32'd0);
    check("rnd_no_timeout", 32'(timeout_err_out), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
